// File: rtl/dadda_final_cpa_if.sv
// Row-pair input and product output handshake bundle for the Dadda final adder.
// The DUT sits on the slave side; the row producer and product consumer share the master side.
interface dadda_final_cpa_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   row_a;
    logic [2*N-1:0]   row_b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   product;
    logic             out_cout;

    modport master (
        output in_valid, row_a, row_b, out_ready,
        input  in_ready, out_valid, product, out_cout
    );

    modport slave (
        input  in_valid, row_a, row_b, out_ready,
        output in_ready, out_valid, product, out_cout
    );
endinterface

// File: rtl/dadda_final_cpa.sv
// Two-stage carry-propagate adder for the reduced Dadda rows: low half in stage 1,
// high half in stage 2, with optional lower-part-OR approximation on the K lowest bits.
module dadda_final_cpa #(
    parameter int N           = 8,
    parameter int APPROX_LSBS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    dadda_final_cpa_if.slave  bus
);
    logic           s1_en;
    logic           s2_en;

    logic           s1_valid;
    logic [N-1:0]   s1_lo;
    logic           s1_c1;
    logic [N-1:0]   s1_hi_a;
    logic [N-1:0]   s1_hi_b;

    logic           out_valid_q;
    logic [2*N-1:0] product_q;
    logic           cout_q;

    logic [N-1:0]   lo_sum;
    logic           lo_carry;
    logic [N:0]     hi_sum;

    assign s2_en        = !out_valid_q | bus.out_ready;
    assign s1_en        = !s1_valid | s2_en;
    assign bus.in_ready = s1_en & rst_n;

    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.out_cout  = cout_q;

    // Approximate bits OR their inputs and leave the AND of the top approximate bit
    // as the carry into the exact ripple section.
    always_comb begin
        lo_sum   = '0;
        lo_carry = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i < APPROX_LSBS) begin
                lo_sum[i] = bus.row_a[i] | bus.row_b[i];
                lo_carry  = bus.row_a[i] & bus.row_b[i];
            end else begin
                lo_sum[i] = bus.row_a[i] ^ bus.row_b[i] ^ lo_carry;
                lo_carry  = (bus.row_a[i] & bus.row_b[i]) |
                            (lo_carry & (bus.row_a[i] ^ bus.row_b[i]));
            end
        end
    end

    assign hi_sum = {1'b0, s1_hi_a} + {1'b0, s1_hi_b} + {{N{1'b0}}, s1_c1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_lo       <= '0;
            s1_c1       <= 1'b0;
            s1_hi_a     <= '0;
            s1_hi_b     <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            cout_q      <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= bus.in_valid & bus.in_ready;
                s1_lo    <= lo_sum;
                s1_c1    <= lo_carry;
                s1_hi_a  <= bus.row_a[2*N-1:N];
                s1_hi_b  <= bus.row_b[2*N-1:N];
            end
            if (s2_en) begin
                out_valid_q <= s1_valid;
                product_q   <= {hi_sum[N-1:0], s1_lo};
                cout_q      <= hi_sum[N];
            end
        end
    end
endmodule
